// File: rtl/alu_step_sequencer_pkg.sv
// Shared encodings for the control unit: opcodes, sequencer states, IR field
// positions and the ALU one-hot layout.
package alu_step_sequencer_pkg;

  localparam int IR_W  = 32;
  localparam int OPC_W = 5;
  localparam int REG_W = 4;

  localparam int OPC_LSB = 27;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;

  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_ROR  = 5'b00111;
  localparam logic [OPC_W-1:0] OPC_ROL  = 5'b01000;
  localparam logic [OPC_W-1:0] OPC_SHR  = 5'b01001;
  localparam logic [OPC_W-1:0] OPC_SHRA = 5'b01010;
  localparam logic [OPC_W-1:0] OPC_SHL  = 5'b01011;
  localparam logic [OPC_W-1:0] OPC_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OPC_DIV  = 5'b10000;
  localparam logic [OPC_W-1:0] OPC_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OPC_NOT  = 5'b10010;

  // Bit positions inside the instruction-level ALU one-hot (IncPC is fetch-only).
  localparam int OP_ADD    = 0;
  localparam int OP_SUB    = 1;
  localparam int OP_AND    = 2;
  localparam int OP_OR     = 3;
  localparam int OP_ROR    = 4;
  localparam int OP_ROL    = 5;
  localparam int OP_SHR    = 6;
  localparam int OP_SHRA   = 7;
  localparam int OP_SHL    = 8;
  localparam int OP_MUL    = 9;
  localparam int OP_DIV    = 10;
  localparam int OP_NEGATE = 11;
  localparam int OP_NOT    = 12;
  localparam int ALU_OPS   = 13;

  typedef logic [ALU_OPS-1:0] alu_oh_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_TRAP
  } state_e;

endpackage

// File: rtl/alu_step_sequencer_alu_op_decode.sv
// Combinational opcode decode: ALU one-hot, operand count, result width and
// legality for the register-register ALU class.
module alu_op_decode
  import alu_step_sequencer_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  output alu_oh_t          o_alu_oh,
  output logic             o_two_operand,
  output logic             o_wide_result,
  output logic             o_legal
);

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    o_alu_oh      = '0;
    o_two_operand = 1'b1;
    o_wide_result = 1'b0;
    o_legal       = 1'b1;
    case (i_opcode)
      OPC_ADD:  o_alu_oh[OP_ADD]  = 1'b1;
      OPC_SUB:  o_alu_oh[OP_SUB]  = 1'b1;
      OPC_AND:  o_alu_oh[OP_AND]  = 1'b1;
      OPC_OR:   o_alu_oh[OP_OR]   = 1'b1;
      OPC_ROR:  o_alu_oh[OP_ROR]  = 1'b1;
      OPC_ROL:  o_alu_oh[OP_ROL]  = 1'b1;
      OPC_SHR:  o_alu_oh[OP_SHR]  = 1'b1;
      OPC_SHRA: o_alu_oh[OP_SHRA] = 1'b1;
      OPC_SHL:  o_alu_oh[OP_SHL]  = 1'b1;
      OPC_MUL: begin
        o_alu_oh[OP_MUL] = 1'b1;
        o_wide_result    = 1'b1;
      end
      OPC_DIV: begin
        o_alu_oh[OP_DIV] = 1'b1;
        o_wide_result    = 1'b1;
      end
      OPC_NEG: begin
        o_alu_oh[OP_NEGATE] = 1'b1;
        o_two_operand       = 1'b0;
      end
      OPC_NOT: begin
        o_alu_oh[OP_NOT] = 1'b1;
        o_two_operand    = 1'b0;
      end
      default: begin
        o_legal       = 1'b0;
        o_two_operand = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_step_sequencer.sv
// T-state control sequencer for fetch and register-register ALU instructions.
// Moore outputs decoded from the state register and IR.
module alu_step_sequencer
  import alu_step_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic [IR_W-1:0]  IR,
  output logic             PCout,
  output logic             ZHighout,
  output logic             ZLowout,
  output logic             MDRout,
  output logic             Rout,
  output logic [REG_W-1:0] Rout_sel,
  output logic             Rin,
  output logic [REG_W-1:0] Rin_sel,
  output logic             PCin,
  output logic             IRin,
  output logic             MARin,
  output logic             MDRin,
  output logic             Yin,
  output logic             Zin,
  output logic             HIin,
  output logic             LOin,
  output logic             Read,
  output logic             ADD,
  output logic             IncPC,
  output logic             AND,
  output logic             OR,
  output logic             NEGATE,
  output logic             NOT,
  output logic             SUB,
  output logic             MUL,
  output logic             DIV,
  output logic             SHR,
  output logic             SHRA,
  output logic             SHL,
  output logic             ROR,
  output logic             ROL,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           r_state;
  state_e           w_next_state;
  logic [CNT_W-1:0] r_retired;

  logic [OPC_W-1:0] w_opcode;
  logic [REG_W-1:0] w_ra;
  logic [REG_W-1:0] w_rb;
  logic [REG_W-1:0] w_rc;
  logic             w_unused_ir;

  alu_oh_t          w_alu_oh;
  alu_oh_t          w_op_en;
  logic             w_two_operand;
  logic             w_wide_result;
  logic             w_legal;

  assign w_opcode    = IR[OPC_LSB +: OPC_W];
  assign w_ra        = IR[RA_LSB +: REG_W];
  assign w_rb        = IR[RB_LSB +: REG_W];
  assign w_rc        = IR[RC_LSB +: REG_W];
  assign w_unused_ir = ^IR[RC_LSB-1:0];

  alu_op_decode u_alu_op_decode (
    .i_opcode      (w_opcode),
    .o_alu_oh      (w_alu_oh),
    .o_two_operand (w_two_operand),
    .o_wide_result (w_wide_result),
    .o_legal       (w_legal)
  );

  always_ff @(posedge clock or posedge clear) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (clear) begin
      r_state   <= S_IDLE;
      r_retired <= '0;
    end else begin
      r_state <= w_next_state;
      if (done) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign retired = r_retired;

  always_comb begin
    w_next_state = r_state;
    PCout        = 1'b0;
    ZHighout     = 1'b0;
    ZLowout      = 1'b0;
    MDRout       = 1'b0;
    Rout         = 1'b0;
    Rout_sel     = '0;
    Rin          = 1'b0;
    Rin_sel      = '0;
    PCin         = 1'b0;
    IRin         = 1'b0;
    MARin        = 1'b0;
    MDRin        = 1'b0;
    Yin          = 1'b0;
    Zin          = 1'b0;
    HIin         = 1'b0;
    LOin         = 1'b0;
    Read         = 1'b0;
    IncPC        = 1'b0;
    w_op_en      = '0;
    done         = 1'b0;
    illegal      = 1'b0;
    case (r_state)
      S_IDLE: if (run) w_next_state = S_T0;
      S_T0: begin
        PCout        = 1'b1;
        MARin        = 1'b1;
        IncPC        = 1'b1;
        Zin          = 1'b1;
        w_next_state = S_T1;
      end
      S_T1: begin
        ZLowout      = 1'b1;
        PCin         = 1'b1;
        Read         = 1'b1;
        MDRin        = 1'b1;
        w_next_state = S_T2;
      end
      S_T2: begin
        MDRout       = 1'b1;
        IRin         = 1'b1;
        w_next_state = S_T3;
      end
      S_T3: begin
        if (w_legal) begin
          Rout         = 1'b1;
          Rout_sel     = w_rb;
          Yin          = 1'b1;
          w_next_state = S_T4;
        end else begin
          w_next_state = S_TRAP;
        end
      end
      S_T4: begin
        w_op_en = w_alu_oh;
        Zin     = 1'b1;
        if (w_two_operand) begin
          Rout     = 1'b1;
          Rout_sel = w_rc;
        end
        w_next_state = S_T5;
      end
      S_T5: begin
        ZLowout = 1'b1;
        if (w_wide_result) begin
          LOin         = 1'b1;
          w_next_state = S_T6;
        end else begin
          Rin          = 1'b1;
          Rin_sel      = w_ra;
          done         = 1'b1;
          w_next_state = run ? S_T0 : S_IDLE;
        end
      end
      S_T6: begin
        ZHighout     = 1'b1;
        HIin         = 1'b1;
        done         = 1'b1;
        w_next_state = run ? S_T0 : S_IDLE;
      end
      // Trap is absorbing; only clear leaves it.
      S_TRAP: illegal = 1'b1;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign ADD    = w_op_en[OP_ADD];
  assign SUB    = w_op_en[OP_SUB];
  assign AND    = w_op_en[OP_AND];
  assign OR     = w_op_en[OP_OR];
  assign ROR    = w_op_en[OP_ROR];
  assign ROL    = w_op_en[OP_ROL];
  assign SHR    = w_op_en[OP_SHR];
  assign SHRA   = w_op_en[OP_SHRA];
  assign SHL    = w_op_en[OP_SHL];
  assign MUL    = w_op_en[OP_MUL];
  assign DIV    = w_op_en[OP_DIV];
  assign NEGATE = w_op_en[OP_NEGATE];
  assign NOT    = w_op_en[OP_NOT];

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Directed-vector bench for alu_step_sequencer: fetch, ALU classes, back-to-back,
// run drop, mid-instruction clear and trap.
module tb_alu_step_sequencer;

  logic        clock;
  logic        clear;
  logic        run;
  logic [31:0] IR;
  logic PCout, ZHighout, ZLowout, MDRout, Rout, Rin, PCin, IRin, MARin, MDRin;
  logic Yin, Zin, HIin, LOin, Read;
  logic ADD, IncPC, AND, OR, NEGATE, NOT, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL;
  logic done, illegal;
  logic [3:0]  Rout_sel;
  logic [3:0]  Rin_sel;
  logic [15:0] retired;

  int          n_checks;
  int          n_fail;
  logic [15:0] exp_retired;
  logic [30:0] obs;

  localparam logic [30:0] B_PCOUT    = 31'h1 << 0;
  localparam logic [30:0] B_ZHIGHOUT = 31'h1 << 1;
  localparam logic [30:0] B_ZLOWOUT  = 31'h1 << 2;
  localparam logic [30:0] B_MDROUT   = 31'h1 << 3;
  localparam logic [30:0] B_ROUT     = 31'h1 << 4;
  localparam logic [30:0] B_RIN      = 31'h1 << 5;
  localparam logic [30:0] B_PCIN     = 31'h1 << 6;
  localparam logic [30:0] B_IRIN     = 31'h1 << 7;
  localparam logic [30:0] B_MARIN    = 31'h1 << 8;
  localparam logic [30:0] B_MDRIN    = 31'h1 << 9;
  localparam logic [30:0] B_YIN      = 31'h1 << 10;
  localparam logic [30:0] B_ZIN      = 31'h1 << 11;
  localparam logic [30:0] B_HIIN     = 31'h1 << 12;
  localparam logic [30:0] B_LOIN     = 31'h1 << 13;
  localparam logic [30:0] B_READ     = 31'h1 << 14;
  localparam logic [30:0] B_ADD      = 31'h1 << 15;
  localparam logic [30:0] B_INCPC    = 31'h1 << 16;
  localparam logic [30:0] B_NEGATE   = 31'h1 << 19;
  localparam logic [30:0] B_MUL      = 31'h1 << 22;
  localparam logic [30:0] B_DIV      = 31'h1 << 23;
  localparam logic [30:0] B_DONE     = 31'h1 << 29;
  localparam logic [30:0] B_ILLEGAL  = 31'h1 << 30;

  localparam logic [30:0] T0_V = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
  localparam logic [30:0] T1_V = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
  localparam logic [30:0] T2_V = B_MDROUT | B_IRIN;

  localparam logic [31:0] IR_ADD = 32'h18918000;
  localparam logic [31:0] IR_NEG = {5'b10001, 4'd4, 4'd5, 4'd0, 15'd0};
  localparam logic [31:0] IR_MUL = {5'b01111, 4'd0, 4'd6, 4'd7, 15'd0};
  localparam logic [31:0] IR_DIV = {5'b10000, 4'd0, 4'd8, 4'd9, 15'd0};
  localparam logic [31:0] IR_BAD = {5'b11111, 27'd0};

  assign obs = {illegal, done, ROL, ROR, SHL, SHRA, SHR, DIV, MUL, SUB, NOT, NEGATE,
                OR, AND, IncPC, ADD, Read, LOin, HIin, Zin, Yin, MDRin, MARin, IRin,
                PCin, Rin, Rout, MDRout, ZLowout, ZHighout, PCout};

  alu_step_sequencer #(.CNT_W(16)) dut (
    .clock(clock), .clear(clear), .run(run), .IR(IR),
    .PCout(PCout), .ZHighout(ZHighout), .ZLowout(ZLowout), .MDRout(MDRout),
    .Rout(Rout), .Rout_sel(Rout_sel), .Rin(Rin), .Rin_sel(Rin_sel),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .Read(Read),
    .ADD(ADD), .IncPC(IncPC), .AND(AND), .OR(OR), .NEGATE(NEGATE), .NOT(NOT),
    .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHRA(SHRA), .SHL(SHL),
    .ROR(ROR), .ROL(ROL), .done(done), .illegal(illegal), .retired(retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    repeat (2) @(negedge clock);
    n_checks++;
    if (obs !== 31'd0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected %b", obs, 31'd0);
    end
    n_checks++;
    if (retired !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_retired: got %0d expected 0", retired);
    end
    clear = 1'b0;
    @(negedge clock);
    n_checks++;
    if (obs !== 31'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b expected %b", obs, 31'd0);
    end
  endtask

  task automatic test_add();
    logic [30:0] ev [6];
    logic [3:0]  rs [6];
    logic [3:0]  ws [6];
    ev = '{T0_V, T1_V, T2_V, B_ROUT | B_YIN, B_ROUT | B_ADD | B_ZIN, B_ZLOWOUT | B_RIN | B_DONE};
    rs = '{4'd0, 4'd0, 4'd0, 4'd2, 4'd3, 4'd0};
    ws = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
    IR  = IR_ADD;
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 5) run = 1'b0;
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL add_step%0d: got %b expected %b", i, obs, ev[i]);
      end
      if (ev[i][4]) begin
        n_checks++;
        if (Rout_sel !== rs[i]) begin
          n_fail++;
          $display("FAIL add_rout_sel%0d: got %0d expected %0d", i, Rout_sel, rs[i]);
        end
      end
      if (ev[i][5]) begin
        n_checks++;
        if (Rin_sel !== ws[i]) begin
          n_fail++;
          $display("FAIL add_rin_sel%0d: got %0d expected %0d", i, Rin_sel, ws[i]);
        end
      end
    end
    exp_retired = exp_retired + 16'd1;
    @(negedge clock);
    n_checks++;
    if (obs !== 31'd0) begin
      n_fail++;
      $display("FAIL add_idle: got %b expected %b", obs, 31'd0);
    end
    n_checks++;
    if (retired !== exp_retired) begin
      n_fail++;
      $display("FAIL add_retired: got %0d expected %0d", retired, exp_retired);
    end
  endtask

  task automatic test_neg();
    logic [30:0] ev [6];
    ev = '{T0_V, T1_V, T2_V, B_ROUT | B_YIN, B_NEGATE | B_ZIN, B_ZLOWOUT | B_RIN | B_DONE};
    IR  = IR_NEG;
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 5) run = 1'b0;
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL neg_step%0d: got %b expected %b", i, obs, ev[i]);
      end
      if (i == 3) begin
        n_checks++;
        if (Rout_sel !== 4'd5) begin
          n_fail++;
          $display("FAIL neg_rout_sel: got %0d expected 5", Rout_sel);
        end
      end
      if (i == 5) begin
        n_checks++;
        if (Rin_sel !== 4'd4) begin
          n_fail++;
          $display("FAIL neg_rin_sel: got %0d expected 4", Rin_sel);
        end
      end
    end
    exp_retired = exp_retired + 16'd1;
    @(negedge clock);
    n_checks++;
    if (retired !== exp_retired || obs !== 31'd0) begin
      n_fail++;
      $display("FAIL neg_retire: got retired %0d strobes %b expected retired %0d strobes 0",
               retired, obs, exp_retired);
    end
  endtask

  task automatic test_back_to_back();
    logic [30:0] ev [14];
    logic [3:0]  rs [14];
    ev = '{T0_V, T1_V, T2_V, B_ROUT | B_YIN, B_ROUT | B_MUL | B_ZIN,
           B_ZLOWOUT | B_LOIN, B_ZHIGHOUT | B_HIIN | B_DONE,
           T0_V, T1_V, T2_V, B_ROUT | B_YIN, B_ROUT | B_DIV | B_ZIN,
           B_ZLOWOUT | B_LOIN, B_ZHIGHOUT | B_HIIN | B_DONE};
    rs = '{4'd0, 4'd0, 4'd0, 4'd6, 4'd7, 4'd0, 4'd0,
           4'd0, 4'd0, 4'd0, 4'd8, 4'd9, 4'd0, 4'd0};
    IR  = IR_MUL;
    run = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL b2b_step%0d: got %b expected %b", i, obs, ev[i]);
      end
      if (ev[i][4]) begin
        n_checks++;
        if (Rout_sel !== rs[i]) begin
          n_fail++;
          $display("FAIL b2b_rout_sel%0d: got %0d expected %0d", i, Rout_sel, rs[i]);
        end
      end
      if (i == 6) IR = IR_DIV;
      if (i == 13) run = 1'b0;
    end
    exp_retired = exp_retired + 16'd2;
    @(negedge clock);
    n_checks++;
    if (retired !== exp_retired || obs !== 31'd0) begin
      n_fail++;
      $display("FAIL b2b_retire: got retired %0d strobes %b expected retired %0d strobes 0",
               retired, obs, exp_retired);
    end
  endtask

  task automatic test_run_drop();
    logic [30:0] ev [6];
    int          dones;
    ev = '{T0_V, T1_V, T2_V, B_ROUT | B_YIN, B_ROUT | B_ADD | B_ZIN, B_ZLOWOUT | B_RIN | B_DONE};
    dones = 0;
    IR  = IR_ADD;
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 2) run = 1'b0;
      if (done === 1'b1) dones++;
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL rundrop_step%0d: got %b expected %b", i, obs, ev[i]);
      end
    end
    exp_retired = exp_retired + 16'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (done === 1'b1) dones++;
      n_checks++;
      if (obs !== 31'd0) begin
        n_fail++;
        $display("FAIL rundrop_idle%0d: got %b expected %b", i, obs, 31'd0);
      end
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL rundrop_done_count: got %0d expected 1", dones);
    end
    n_checks++;
    if (retired !== exp_retired) begin
      n_fail++;
      $display("FAIL rundrop_retired: got %0d expected %0d", retired, exp_retired);
    end
  endtask

  task automatic test_reset_mid();
    IR  = IR_ADD;
    run = 1'b1;
    repeat (5) @(negedge clock);
    n_checks++;
    if (obs !== (B_ROUT | B_ADD | B_ZIN)) begin
      n_fail++;
      $display("FAIL mid_t4: got %b expected %b", obs, B_ROUT | B_ADD | B_ZIN);
    end
    clear = 1'b1;
    #1;
    n_checks++;
    if (obs !== 31'd0) begin
      n_fail++;
      $display("FAIL mid_clear_strobes: got %b expected %b", obs, 31'd0);
    end
    n_checks++;
    if (retired !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_clear_retired: got %0d expected 0", retired);
    end
    exp_retired = 16'd0;
    run = 1'b0;
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    n_checks++;
    if (obs !== 31'd0) begin
      n_fail++;
      $display("FAIL mid_idle_hold: got %b expected %b", obs, 31'd0);
    end
    run = 1'b1;
    @(negedge clock);
    n_checks++;
    if (obs !== T0_V) begin
      n_fail++;
      $display("FAIL mid_first_t0: got %b expected %b", obs, T0_V);
    end
    run   = 1'b0;
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_trap();
    logic [30:0] ev [4];
    ev = '{T0_V, T1_V, T2_V, 31'd0};
    IR  = IR_BAD;
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL trap_step%0d: got %b expected %b", i, obs, ev[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      run = ~run;
      n_checks++;
      if (obs !== B_ILLEGAL) begin
        n_fail++;
        $display("FAIL trap_hold%0d: got %b expected %b", i, obs, B_ILLEGAL);
      end
    end
    clear = 1'b1;
    #1;
    n_checks++;
    if (obs !== 31'd0) begin
      n_fail++;
      $display("FAIL trap_clear: got %b expected %b", obs, 31'd0);
    end
    run = 1'b0;
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    n_checks++;
    if (obs !== 31'd0 || retired !== 16'd0) begin
      n_fail++;
      $display("FAIL trap_after_clear: got strobes %b retired %0d expected 0 and 0", obs, retired);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    exp_retired = 16'd0;
    clear       = 1'b1;
    run         = 1'b0;
    IR          = 32'd0;
    test_reset();
    test_add();
    test_neg();
    test_back_to_back();
    test_run_drop();
    test_reset_mid();
    test_trap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
